ex_mdu_stage: RTL and testbench
===============================

# ex_mdu_stage

Parametrised multiply/divide execution unit implementing the RV32M extension. It sits beside the single-cycle EX ALU and receives post-forwarding operands and the rd address. It holds the pipeline through a busy/stall request while a multi-cycle operation runs, then presents a registered write-back result to the MA stage.

## Interface
Parameters:
- XLEN, 32: operand and result width; must be even and ≥ 8.
- MUL_STAGES, 2: multiplier latency in cycles, legal range 1..4.
- DIV_BITS, 1: quotient bits retired per divider cycle; legal values 1 or 2. XLEN must be divisible by DIV_BITS.

Ports:
- clk  in  1  single clock; all logic on its rising edge.
- rst  in  1  reset, synchronous and active-high.
- start_ex  in  1  a valid M-extension op is in EX (opcode OP, funct7 = 0000001, not purged).
- funct3_ex  in  3  op select: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
- rs1_ex  in  XLEN  dividend / multiplicand, already forwarded.
- rs2_ex  in  XLEN  divisor / multiplier, already forwarded.
- rd_adr_ex  in  5  destination register.
- flush  in  1  pipeline purge (jump purge or rst_pipe); aborts any operation.
- stall  in  1  downstream stall; holds the DONE result.
- mdu_busy  out  1  stall request to IF/ID/EX.
- done_ma  out  1  result valid toward MA.
- rd_data_ma  out  XLEN  result.
- rd_adr_ma  out  5  destination register.
- wbk_rd_reg_ma  out  1  write-back enable; equals done_ma & (rd_adr_ma != 0).

## Operation
- States:
  - IDLE → MUL on start_ex with funct3[2] = 0.
  - IDLE → DIV on start_ex with funct3[2] = 1.
  - IDLE → DONE on start_ex for a divide special case.
  - MUL → DONE after MUL_STAGES−1 further cycles.
  - DIV → FIX after XLEN/DIV_BITS iterations.
  - FIX → DONE.
  - DONE → IDLE when ~stall.
- Operands, funct3 and rd are latched at IDLE acceptance. start_ex in any other state is ignored.
- Multiply:
  - Form signed (XLEN+1)-bit extensions of both operands: rs1 is sign-extended for MULH/MULHSU; rs2 is sign-extended for MULH only.
  - Take the (2·XLEN+2)-bit product. MUL returns the low XLEN bits; all others return bits [2·XLEN−1:XLEN].
- Divide:
  - Restoring division on operand magnitudes (signed ops for DIV/REM), DIV_BITS bits per cycle.
  - FIX applies signs: quotient negated if the operand signs differ; remainder takes the dividend sign.
- Special cases, resolved in IDLE with no iteration:
  - Divisor 0: quotient all-ones, remainder = rs1.
  - Signed overflow (rs1 = most-negative, rs2 = −1): quotient = rs1, remainder = 0.
- mdu_busy = (IDLE & start_ex & ~flush) | MUL | DIV | FIX. It is low in DONE so the pipeline advances while the result is in MA.
- flush in any state: return to IDLE next cycle; done_ma stays low; no write-back. A flush takes priority over start_ex in the same cycle.
- rst: all state to IDLE. Outputs reset to mdu_busy 0, done_ma 0, rd_data_ma 0, rd_adr_ma 0, wbk_rd_reg_ma 0. rst mid-operation discards the operation.

## Timing
Start is accepted at cycle 0.
- Multiply: done_ma is high at cycle MUL_STAGES.
- Divide: done_ma is high at cycle XLEN/DIV_BITS + 2, which is 34 at the defaults.
- Divide special case: done_ma is high at cycle 1.
- done_ma lasts exactly one cycle unless stall is high; while stalled, DONE and all outputs are held stable.
- Back-to-back operations: a new start_ex is accepted in the IDLE cycle that follows DONE.

## Configuration
- MDU_DIV_EN defined: the divider, FIX state and special-case logic are built; full RV32M.
- MDU_DIV_EN undefined: the divider hardware is omitted. funct3[2] = 1 ops go straight to DONE at cycle 1 with rd_data_ma = 0, giving a multiply-only configuration.

## Structure
- Shared package (cpu-wide RV definitions):
  - funct3 encodings for MUL..REMU as localparams.
  - MDU state encoding typedef: IDLE, MUL, DIV, FIX, DONE.
- Sub-module mdu_divider, parametrised by XLEN and DIV_BITS:
  - Takes magnitudes and a start pulse; returns quotient/remainder and a done pulse.
  - The whole instance is under MDU_DIV_EN.
- The multiplier pipeline stays inline as MUL_STAGES register stages.

## Test plan
- MULH, rs1 = 0x8000_0000, rs2 = 0x8000_0000 → rd_data = 0x4000_0000, done_ma at cycle 2. MULHSU with rs1 = 0xFFFF_FFFF, rs2 = 0xFFFF_FFFF → 0xFFFF_FFFF. MULHU on the same operands → 0xFFFF_FFFE.
- DIVU 100 / 7 → 14 at cycle 34. REM −100 / 7 → −2 (0xFFFF_FFFE). DIV −100 / 7 → −14. mdu_busy is high for cycles 0..33.
- DIV 5 / 0 → 0xFFFF_FFFF at cycle 1. REM 0x8000_0000 / −1 → 0. DIV 0x8000_0000 / −1 → 0x8000_0000.
- flush asserted at cycle 10 of a DIV → IDLE at cycle 11; no done_ma and mdu_busy low thereafter. Same check with rst at cycle 10; all outputs 0 after reset.
- stall held for 3 cycles in DONE → done_ma and rd_data_ma stable for 4 cycles. A start_ex during DONE is ignored. An op with rd = x0 → done_ma 1, wbk_rd_reg_ma 0.
- Parameter sweep: DIV_BITS = 2 → DIVU done at cycle 18. MUL_STAGES = 4 → done at cycle 4. Build without MDU_DIV_EN → DIV returns 0 at cycle 1.

Source files
------------

// File: rtl/ex_mdu_stage_pkg.sv
// Shared RV32M definitions: M-extension funct3 encodings and the MDU FSM state encoding.
package ex_mdu_stage_pkg;

  localparam logic [2:0] F3_MUL    = 3'd0;
  localparam logic [2:0] F3_MULH   = 3'd1;
  localparam logic [2:0] F3_MULHSU = 3'd2;
  localparam logic [2:0] F3_MULHU  = 3'd3;
  localparam logic [2:0] F3_DIV    = 3'd4;
  localparam logic [2:0] F3_DIVU   = 3'd5;
  localparam logic [2:0] F3_REM    = 3'd6;
  localparam logic [2:0] F3_REMU   = 3'd7;

  typedef logic [2:0] mdu_state_t;

  localparam mdu_state_t ST_IDLE = 3'd0;
  localparam mdu_state_t ST_MUL  = 3'd1;
  localparam mdu_state_t ST_DIV  = 3'd2;
  localparam mdu_state_t ST_FIX  = 3'd3;
  localparam mdu_state_t ST_DONE = 3'd4;

endpackage

// File: rtl/ex_mdu_stage_divider.sv
// mdu_divider: unsigned restoring divider retiring DIV_BITS quotient bits per cycle.
// Only instantiated when MDU_DIV_EN is defined.
module mdu_divider #(
  parameter int XLEN     = 32,
  parameter int DIV_BITS = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_start,
  input  logic            i_abort,
  input  logic [XLEN-1:0] i_dividend,
  input  logic [XLEN-1:0] i_divisor,
  output logic            o_done,
  output logic [XLEN-1:0] o_quot,
  output logic [XLEN-1:0] o_rem
);
  localparam int ITER = XLEN / DIV_BITS;
  localparam int CW   = $clog2(ITER + 1);

  logic [XLEN-1:0] r_q;
  logic [XLEN-1:0] r_d;
  logic [XLEN-1:0] r_rem;
  logic [CW-1:0]   r_cnt;
  logic            r_busy;
  logic [XLEN-1:0] w_q_nxt;
  logic [XLEN-1:0] w_rem_nxt;
  logic [XLEN:0]   w_trial;

  // DIV_BITS restoring steps: shift in the next dividend bit, subtract when it fits.
  always_comb begin
    w_q_nxt   = r_q;
    w_rem_nxt = r_rem;
    w_trial   = '0;
    for (int k = 0; k < DIV_BITS; k++) begin
      w_trial = {w_rem_nxt, w_q_nxt[XLEN-1]};
      w_q_nxt = {w_q_nxt[XLEN-2:0], 1'b0};
      if (w_trial >= {1'b0, r_d}) begin
        w_trial    = w_trial - {1'b0, r_d};
        w_q_nxt[0] = 1'b1;
      end else begin
        w_q_nxt[0] = 1'b0;
      end
      w_rem_nxt = w_trial[XLEN-1:0];
    end
  end

  // Iteration state: load on start, step while busy, drop on abort.
  always_ff @(posedge clk) begin
    if (rst || i_abort) begin
      r_busy <= 1'b0;
      r_cnt  <= '0;
      r_q    <= '0;
      r_rem  <= '0;
      r_d    <= '0;
    end else if (i_start) begin
      r_busy <= 1'b1;
      r_cnt  <= CW'(ITER);
      r_q    <= i_dividend;
      r_rem  <= '0;
      r_d    <= i_divisor;
    end else if (r_busy) begin
      r_q    <= w_q_nxt;
      r_rem  <= w_rem_nxt;
      r_cnt  <= r_cnt - CW'(1);
      r_busy <= (r_cnt != CW'(1));
    end else begin
      r_busy <= 1'b0;
    end
  end

  // Raised during the final iteration so the caller can move on as the result lands.
  assign o_done = r_busy && (r_cnt == CW'(1));
  assign o_quot = r_q;
  assign o_rem  = r_rem;

endmodule

// File: rtl/ex_mdu_stage.sv
// ex_mdu_stage: RV32M multiply/divide EX unit with pipeline stall request and registered MA result.
// Define MDU_DIV_EN to build the divider; otherwise divide ops finish at once returning zero.
module ex_mdu_stage
  import ex_mdu_stage_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int MUL_STAGES = 2,
  parameter int DIV_BITS   = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start_ex,
  input  logic [2:0]      funct3_ex,
  input  logic [XLEN-1:0] rs1_ex,
  input  logic [XLEN-1:0] rs2_ex,
  input  logic [4:0]      rd_adr_ex,
  input  logic            flush,
  input  logic            stall,
  output logic            mdu_busy,
  output logic            done_ma,
  output logic [XLEN-1:0] rd_data_ma,
  output logic [4:0]      rd_adr_ma,
  output logic            wbk_rd_reg_ma
);
  localparam int         NSTG     = (MUL_STAGES > 1) ? MUL_STAGES - 1 : 1;
  localparam int         LAST     = NSTG - 1;
  localparam logic [2:0] CNT_INIT = 3'(NSTG - 1);

  mdu_state_t        r_state;
  mdu_state_t        w_state_nxt;
  logic [2:0]        r_funct3;
  logic [4:0]        r_rd;
  logic [2:0]        r_cnt;
  logic [2*XLEN-1:0] r_prod [NSTG];
  logic              r_done;
  logic [XLEN-1:0]   r_data;
  logic [4:0]        r_rd_ma;
  logic              r_wbk;

  logic              w_accept;
  logic              w_is_div;
  logic              w_a_sx;
  logic              w_b_sx;
  logic [2*XLEN-1:0] w_a_wide;
  logic [2*XLEN-1:0] w_b_wide;
  logic [2*XLEN-1:0] w_prod_in;
  logic              w_special;
  logic [XLEN-1:0]   w_special_res;
  logic              w_div_done;
  logic [XLEN-1:0]   w_fix_res;
  logic              w_load;
  logic [XLEN-1:0]   w_res;
  logic [4:0]        w_rd_sel;

  function automatic logic [XLEN-1:0] mul_select(input logic [2:0] f3, input logic [2*XLEN-1:0] p);
    if (f3 == F3_MUL) begin
      return p[XLEN-1:0];
    end else begin
      return p[2*XLEN-1:XLEN];
    end
  endfunction

  assign w_accept = (r_state == ST_IDLE) && start_ex && !flush;
  assign w_is_div = funct3_ex[2];
  assign w_a_sx   = (funct3_ex == F3_MULH) || (funct3_ex == F3_MULHSU);
  assign w_b_sx   = (funct3_ex == F3_MULH);
  // Only the low 2*XLEN product bits are ever selected, so the extension stops there.
  assign w_a_wide  = {{XLEN{w_a_sx & rs1_ex[XLEN-1]}}, rs1_ex};
  assign w_b_wide  = {{XLEN{w_b_sx & rs2_ex[XLEN-1]}}, rs2_ex};
  assign w_prod_in = w_a_wide * w_b_wide;

`ifdef MDU_DIV_EN
  logic            w_signed_op;
  logic            w_div_zero;
  logic            w_div_ovf;
  logic [XLEN-1:0] w_mag_a;
  logic [XLEN-1:0] w_mag_b;
  logic [XLEN-1:0] w_quot;
  logic [XLEN-1:0] w_rem;
  logic            r_neg_q;
  logic            r_neg_r;

  // Special-case detection and operand magnitudes for the divider.
  always_comb begin
    w_signed_op   = !funct3_ex[0];
    w_div_zero    = (rs2_ex == '0);
    w_div_ovf     = w_signed_op && (rs1_ex == {1'b1, {(XLEN-1){1'b0}}}) && (rs2_ex == '1);
    w_special     = w_div_zero || w_div_ovf;
    w_special_res = funct3_ex[1] ? (w_div_zero ? rs1_ex : '0) : (w_div_zero ? '1 : rs1_ex);
    w_mag_a       = (w_signed_op && rs1_ex[XLEN-1]) ? -rs1_ex : rs1_ex;
    w_mag_b       = (w_signed_op && rs2_ex[XLEN-1]) ? -rs2_ex : rs2_ex;
    w_fix_res     = r_funct3[1] ? (r_neg_r ? -w_rem : w_rem) : (r_neg_q ? -w_quot : w_quot);
  end

  // Result signs captured at acceptance, applied in FIX.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
    end else if (w_accept) begin
      r_neg_q <= w_signed_op && (rs1_ex[XLEN-1] ^ rs2_ex[XLEN-1]);
      r_neg_r <= w_signed_op && rs1_ex[XLEN-1];
    end else begin
      r_neg_q <= r_neg_q;
      r_neg_r <= r_neg_r;
    end
  end

  mdu_divider #(
    .XLEN     (XLEN),
    .DIV_BITS (DIV_BITS)
  ) u_div (
    .clk        (clk),
    .rst        (rst),
    .i_start    (w_accept && w_is_div && !w_special),
    .i_abort    (flush),
    .i_dividend (w_mag_a),
    .i_divisor  (w_mag_b),
    .o_done     (w_div_done),
    .o_quot     (w_quot),
    .o_rem      (w_rem)
  );
`else
  // Multiply-only build: every divide op resolves immediately to zero.
  always_comb begin
    w_special     = 1'b1;
    w_special_res = '0;
    w_div_done    = 1'b0;
    w_fix_res     = '0;
  end
`endif

  // Next-state logic; w_load marks the cycle whose result enters DONE.
  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_res       = '0;
    w_rd_sel    = r_rd;
    case (r_state)
      ST_IDLE: begin
        if (start_ex) begin
          w_rd_sel = rd_adr_ex;
          if (w_is_div) begin
            if (w_special) begin
              w_state_nxt = ST_DONE;
              w_load      = 1'b1;
              w_res       = w_special_res;
            end else begin
              w_state_nxt = ST_DIV;
            end
          end else if (MUL_STAGES == 1) begin
            w_state_nxt = ST_DONE;
            w_load      = 1'b1;
            w_res       = mul_select(funct3_ex, w_prod_in);
          end else begin
            w_state_nxt = ST_MUL;
          end
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_MUL: begin
        if (r_cnt == 3'd0) begin
          w_state_nxt = ST_DONE;
          w_load      = 1'b1;
          w_res       = mul_select(r_funct3, r_prod[LAST]);
        end else begin
          w_state_nxt = ST_MUL;
        end
      end
      ST_DIV:  w_state_nxt = w_div_done ? ST_FIX : ST_DIV;
      ST_FIX: begin
        w_state_nxt = ST_DONE;
        w_load      = 1'b1;
        w_res       = w_fix_res;
      end
      ST_DONE: w_state_nxt = stall ? ST_DONE : ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
    if (flush) begin
      w_state_nxt = ST_IDLE;
      w_load      = 1'b0;
    end else begin
      w_load      = w_load;
    end
  end

  // FSM, op latches and the registered MA-facing result.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_funct3 <= 3'd0;
      r_rd     <= 5'd0;
      r_cnt    <= 3'd0;
      r_done   <= 1'b0;
      r_data   <= '0;
      r_rd_ma  <= 5'd0;
      r_wbk    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_funct3 <= funct3_ex;
        r_rd     <= rd_adr_ex;
        r_cnt    <= CNT_INIT;
      end else if (r_state == ST_MUL) begin
        r_cnt    <= r_cnt - 3'd1;
      end else begin
        r_cnt    <= r_cnt;
      end
      if (w_load) begin
        r_done  <= 1'b1;
        r_data  <= w_res;
        r_rd_ma <= w_rd_sel;
        r_wbk   <= (w_rd_sel != 5'd0);
      end else if (w_state_nxt != ST_DONE) begin
        r_done  <= 1'b0;
        r_wbk   <= 1'b0;
      end else begin
        r_done  <= r_done;
        r_wbk   <= r_wbk;
      end
    end
  end

  // Multiplier pipeline: product captured at acceptance, then shifted each cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < NSTG; k++) r_prod[k] <= '0;
    end else begin
      if (w_accept) begin
        r_prod[0] <= w_prod_in;
      end else begin
        r_prod[0] <= r_prod[0];
      end
      for (int k = 1; k < NSTG; k++) r_prod[k] <= r_prod[k-1];
    end
  end

  assign mdu_busy      = w_accept || (r_state == ST_MUL) || (r_state == ST_DIV) || (r_state == ST_FIX);
  assign done_ma       = r_done;
  assign rd_data_ma    = r_data;
  assign rd_adr_ma     = r_rd_ma;
  assign wbk_rd_reg_ma = r_wbk;

endmodule

// File: tb/tb_ex_mdu_stage.sv
// Directed bench for ex_mdu_stage: default instance plus a MUL_STAGES=4 / DIV_BITS=2 instance.
module tb_ex_mdu_stage;
  import ex_mdu_stage_pkg::*;

`ifdef MDU_DIV_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif

  typedef struct {
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;
    logic [31:0] res;
    int          lat;
  } vec_t;

  localparam int NV = 18;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_ex, flush, stall;
  logic [2:0]  funct3_ex;
  logic [31:0] rs1_ex, rs2_ex;
  logic [4:0]  rd_adr_ex;
  logic        mdu_busy, done_ma, wbk_rd_reg_ma;
  logic [31:0] rd_data_ma;
  logic [4:0]  rd_adr_ma;

  logic        s4_start, s4_flush, s4_stall;
  logic [2:0]  s4_funct3;
  logic [31:0] s4_rs1, s4_rs2;
  logic [4:0]  s4_rd;
  logic        s4_busy, s4_done, s4_wbk;
  logic [31:0] s4_data;
  logic [4:0]  s4_rd_ma;

  int   n_assert = 0;
  int   n_fail   = 0;
  vec_t vecs [NV];

  always #5 clk = ~clk;

  ex_mdu_stage u_dut (
    .clk(clk), .rst(rst), .start_ex(start_ex), .funct3_ex(funct3_ex), .rs1_ex(rs1_ex),
    .rs2_ex(rs2_ex), .rd_adr_ex(rd_adr_ex), .flush(flush), .stall(stall), .mdu_busy(mdu_busy),
    .done_ma(done_ma), .rd_data_ma(rd_data_ma), .rd_adr_ma(rd_adr_ma), .wbk_rd_reg_ma(wbk_rd_reg_ma)
  );

  ex_mdu_stage #(.XLEN(32), .MUL_STAGES(4), .DIV_BITS(2)) u_dut4 (
    .clk(clk), .rst(rst), .start_ex(s4_start), .funct3_ex(s4_funct3), .rs1_ex(s4_rs1),
    .rs2_ex(s4_rs2), .rd_adr_ex(s4_rd), .flush(s4_flush), .stall(s4_stall), .mdu_busy(s4_busy),
    .done_ma(s4_done), .rd_data_ma(s4_data), .rd_adr_ma(s4_rd_ma), .wbk_rd_reg_ma(s4_wbk)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // One op on the default instance; returns done latency, result and busy profile.
  task automatic do_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd, output int lat, output logic [31:0] res,
                       output logic wbk, output int bcyc, output logic bdone);
    lat = -1; res = '0; wbk = 1'b0; bdone = 1'b1;
    @(negedge clk);
    start_ex = 1'b1; funct3_ex = f3; rs1_ex = a; rs2_ex = b; rd_adr_ex = rd;
    #1;
    bcyc = mdu_busy ? 1 : 0;
    @(posedge clk); #1;
    start_ex = 1'b0;
    for (int c = 1; c <= 60; c++) begin
      if (done_ma) begin
        lat = c; res = rd_data_ma; wbk = wbk_rd_reg_ma; bdone = mdu_busy;
        break;
      end
      bcyc += mdu_busy ? 1 : 0;
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
  endtask

  task automatic op4(input string name, input logic [2:0] f3, input logic [31:0] a,
                     input logic [31:0] b, input logic [31:0] exp_res, input int exp_lat);
    int          lat;
    logic [31:0] res;
    lat = -1; res = '0;
    @(negedge clk);
    s4_start = 1'b1; s4_funct3 = f3; s4_rs1 = a; s4_rs2 = b; s4_rd = 5'd3;
    @(posedge clk); #1;
    s4_start = 1'b0;
    for (int c = 1; c <= 60; c++) begin
      if (s4_done) begin
        lat = c; res = s4_data;
        break;
      end
      @(posedge clk); #1;
    end
    chk({name, "_res"}, res, exp_res);
    chk({name, "_lat"}, 32'(lat), 32'(exp_lat));
    @(posedge clk); #1;
  endtask

  initial begin
    int          lat, bcyc, ndone, nbusy, nbad;
    logic [31:0] res;
    logic        wbk, bdone;

    vecs[0]  = '{F3_MULH,   32'h8000_0000, 32'h8000_0000, 5'd1,  32'h4000_0000, 2};
    vecs[1]  = '{F3_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2,  32'hFFFF_FFFF, 2};
    vecs[2]  = '{F3_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3,  32'hFFFF_FFFE, 2};
    vecs[3]  = '{F3_MUL,    32'h1234_5678, 32'h0000_0010, 5'd4,  32'h2345_6780, 2};
    vecs[4]  = '{F3_MUL,    32'hFFFF_FFFD, 32'd7,         5'd0,  32'hFFFF_FFEB, 2};
    vecs[5]  = '{F3_MULH,   32'hFFFF_FFFD, 32'd7,         5'd5,  32'hFFFF_FFFF, 2};
    vecs[6]  = '{F3_MULHU,  32'h8000_0000, 32'd4,         5'd6,  32'h0000_0002, 2};
    vecs[7]  = '{F3_MULH,   32'd7,         32'd6,         5'd7,  32'h0000_0000, 2};
    vecs[8]  = '{F3_DIVU,   32'd100,       32'd7,         5'd8,  DIV_EN ? 32'd14 : 32'd0, DIV_EN ? 34 : 1};
    vecs[9]  = '{F3_REM,    32'hFFFF_FF9C, 32'd7,         5'd9,  DIV_EN ? 32'hFFFF_FFFE : 32'd0, DIV_EN ? 34 : 1};
    vecs[10] = '{F3_DIV,    32'hFFFF_FF9C, 32'd7,         5'd10, DIV_EN ? 32'hFFFF_FFF2 : 32'd0, DIV_EN ? 34 : 1};
    vecs[11] = '{F3_REMU,   32'd100,       32'd7,         5'd11, DIV_EN ? 32'd2 : 32'd0, DIV_EN ? 34 : 1};
    vecs[12] = '{F3_DIV,    32'd5,         32'd0,         5'd12, DIV_EN ? 32'hFFFF_FFFF : 32'd0, 1};
    vecs[13] = '{F3_REM,    32'h8000_0000, 32'hFFFF_FFFF, 5'd13, 32'd0, 1};
    vecs[14] = '{F3_DIV,    32'h8000_0000, 32'hFFFF_FFFF, 5'd14, DIV_EN ? 32'h8000_0000 : 32'd0, 1};
    vecs[15] = '{F3_REMU,   32'd5,         32'd0,         5'd15, DIV_EN ? 32'd5 : 32'd0, 1};
    vecs[16] = '{F3_DIV,    32'd7,         32'hFFFF_FFFE, 5'd16, DIV_EN ? 32'hFFFF_FFFD : 32'd0, DIV_EN ? 34 : 1};
    vecs[17] = '{F3_DIVU,   32'hFFFF_FFFF, 32'd1,         5'd0,  DIV_EN ? 32'hFFFF_FFFF : 32'd0, DIV_EN ? 34 : 1};

    rst = 1'b1; start_ex = 1'b0; flush = 1'b0; stall = 1'b0;
    funct3_ex = 3'd0; rs1_ex = '0; rs2_ex = '0; rd_adr_ex = 5'd0;
    s4_start = 1'b0; s4_flush = 1'b0; s4_stall = 1'b0;
    s4_funct3 = 3'd0; s4_rs1 = '0; s4_rs2 = '0; s4_rd = 5'd0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_done", {31'd0, done_ma}, 32'd0);
    chk("rst_data", rd_data_ma, 32'd0);
    chk("rst_rd", {27'd0, rd_adr_ma}, 32'd0);
    chk("rst_wbk", {31'd0, wbk_rd_reg_ma}, 32'd0);
    chk("rst_busy", {31'd0, mdu_busy}, 32'd0);
    rst = 1'b0;

    for (int i = 0; i < NV; i++) begin
      do_op(vecs[i].f3, vecs[i].a, vecs[i].b, vecs[i].rd, lat, res, wbk, bcyc, bdone);
      chk($sformatf("v%0d_res", i), res, vecs[i].res);
      chk($sformatf("v%0d_lat", i), 32'(lat), 32'(vecs[i].lat));
      chk($sformatf("v%0d_wbk", i), {31'd0, wbk}, {31'd0, vecs[i].rd != 5'd0});
      chk($sformatf("v%0d_busy_cycles", i), 32'(bcyc), 32'(vecs[i].lat));
      chk($sformatf("v%0d_busy_at_done", i), {31'd0, bdone}, 32'd0);
    end

    // Flush at cycle 10 of a divide.
    @(negedge clk);
    start_ex = 1'b1; funct3_ex = F3_DIVU; rs1_ex = 32'd100; rs2_ex = 32'd7; rd_adr_ex = 5'd9;
    @(posedge clk); #1;
    start_ex = 1'b0;
    ndone = 0;
    for (int c = 1; c < 10; c++) begin
      ndone += done_ma ? 1 : 0;
      @(posedge clk); #1;
    end
    flush = 1'b1;
    ndone += done_ma ? 1 : 0;
    @(posedge clk); #1;
    flush = 1'b0;
    chk("flush_busy_c11", {31'd0, mdu_busy}, 32'd0);
    nbusy = 0;
    for (int c = 0; c < 40; c++) begin
      ndone += done_ma ? 1 : 0;
      nbusy += mdu_busy ? 1 : 0;
      @(posedge clk); #1;
    end
    chk("flush_done_count", 32'(ndone), DIV_EN ? 32'd0 : 32'd1);
    chk("flush_busy_after", 32'(nbusy), 32'd0);

    // Reset at cycle 10 of a divide.
    @(negedge clk);
    start_ex = 1'b1; funct3_ex = F3_DIV; rs1_ex = 32'd77; rs2_ex = 32'd5; rd_adr_ex = 5'd21;
    @(posedge clk); #1;
    start_ex = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("rstmid_done", {31'd0, done_ma}, 32'd0);
    chk("rstmid_data", rd_data_ma, 32'd0);
    chk("rstmid_rd", {27'd0, rd_adr_ma}, 32'd0);
    chk("rstmid_wbk", {31'd0, wbk_rd_reg_ma}, 32'd0);
    chk("rstmid_busy", {31'd0, mdu_busy}, 32'd0);
    ndone = 0;
    for (int c = 0; c < 40; c++) begin
      ndone += done_ma ? 1 : 0;
      @(posedge clk); #1;
    end
    chk("rstmid_no_done", 32'(ndone), 32'd0);

    // Stall held in DONE for cycles 2..4, with an ignored start in cycle 3.
    stall = 1'b1;
    @(negedge clk);
    start_ex = 1'b1; funct3_ex = F3_MULHU; rs1_ex = 32'hFFFF_FFFF; rs2_ex = 32'hFFFF_FFFF; rd_adr_ex = 5'd17;
    @(posedge clk); #1;
    start_ex = 1'b0;
    ndone = 0; nbad = 0;
    for (int c = 1; c <= 10; c++) begin
      if (c == 3) begin
        start_ex = 1'b1; funct3_ex = F3_MUL; rs1_ex = 32'd5; rs2_ex = 32'd5; rd_adr_ex = 5'd18;
        #1;
        chk("stall_start_busy", {31'd0, mdu_busy}, 32'd0);
      end
      if (c == 5) stall = 1'b0;
      if (done_ma) begin
        ndone++;
        if (rd_data_ma !== 32'hFFFF_FFFE || rd_adr_ma !== 5'd17) nbad++;
      end
      @(posedge clk); #1;
      start_ex = 1'b0;
    end
    chk("stall_done_cycles", 32'(ndone), 32'd4);
    chk("stall_data_stable", 32'(nbad), 32'd0);

    // Parameter-swept instance.
    op4("p4_mulhu", F3_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 4);
    op4("p4_mul", F3_MUL, 32'h1234_5678, 32'h0000_0010, 32'h2345_6780, 4);
    op4("p4_divu", F3_DIVU, 32'd100, 32'd7, DIV_EN ? 32'd14 : 32'd0, DIV_EN ? 18 : 1);
    op4("p4_divu3", F3_DIVU, 32'hFFFF_FFFF, 32'd3, DIV_EN ? 32'h5555_5555 : 32'd0, DIV_EN ? 18 : 1);
    op4("p4_remu", F3_REMU, 32'd100, 32'd7, DIV_EN ? 32'd2 : 32'd0, DIV_EN ? 18 : 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
